serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_tx_bit_timer.sv | 43 ++++
 rtl/serial_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// FSM encoding, idle line level and parity mode.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // 0 selects even parity: the parity bit is the plain XOR of the data bits
  localparam logic PARITY_ODD = 1'b0;

  // Counter width that stays legal (>=1) when the count range is a single value
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick (registered)
// during the last cycle of each bit period; clear holds it at the start.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick is precomputed from the next count so it lines up with cnt_q == LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, LSB-first data, optional even
// parity, stop bit; valid/ready word intake and a done pulse per frame.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              doutb,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = cnt_w(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              dout_q, dout_d;
  logic              doutb_q;
  logic              busy_q, busy_d;
  logic              din_ready_q, din_ready_d;
  logic              done_q, done_d;

  logic tick;
  logic timer_clear;
  logic accept;

  assign accept      = din_valid && din_ready_q;
  assign timer_clear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // Next state and next line level; dout_d is the bit for the coming cycle
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    dout_d    = dout_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        dout_d = LINE_IDLE;
        if (accept) begin
          state_d  = START;
          shift_d  = din;
          parity_d = (^din) ^ PARITY_ODD;
          dout_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          dout_d    = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              dout_d  = parity_q;
            end else begin
              state_d = STOP;
              dout_d  = LINE_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            dout_d    = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          dout_d  = LINE_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          dout_d  = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = LINE_IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    din_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      parity_q    <= 1'b0;
      dout_q      <= LINE_IDLE;
      doutb_q     <= ~LINE_IDLE;
      busy_q      <= 1'b0;
      din_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      parity_q    <= parity_d;
      dout_q      <= dout_d;
      doutb_q     <= ~dout_d;
      busy_q      <= busy_d;
      din_ready_q <= din_ready_d;
      done_q      <= done_d;
    end
  end

  assign dout      = dout_q;
  assign doutb     = doutb_q;
  assign busy      = busy_q;
  assign din_ready = din_ready_q;
  assign done      = done_q;

endmodule
